// File: rtl/din_debounce_edge_pkg.sv
// Shared types for the din debounce/edge conditioning stage.
package debounce_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } state_t;
endpackage

// File: rtl/din_debounce_edge_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level into clk.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/din_debounce_edge.sv
// Debounces a raw asynchronous level; emits a clean level q plus one-cycle
// rise/fall pulses, with busy flagging a candidate transition being timed.
module din_debounce_edge
  import debounce_pkg::*;
#(
  parameter int   CNT_W         = 16,
  parameter int   STABLE_CYCLES = 50000,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic clear_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);
  if (STABLE_CYCLES < 1 || longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_param
    $error("din_debounce_edge: STABLE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  sync_2ff #(.RESET_VAL(INIT_LEVEL)) u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (din),
    .q       (s2)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
      cnt   <= '0;
      q     <= INIT_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        STABLE_LO: begin
          cnt <= '0;
          if (s2) begin
            // A one-cycle window commits on the first sample, skipping PEND.
            if (STABLE_CYCLES == 1) begin
              state <= STABLE_HI;
              q     <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= PEND_HI;
              cnt   <= CNT_W'(1);
              busy  <= 1'b1;
            end
          end
        end
        PEND_HI: begin
          if (!s2) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            q     <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          cnt <= '0;
          if (!s2) begin
            if (STABLE_CYCLES == 1) begin
              state <= STABLE_LO;
              q     <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= PEND_LO;
              cnt   <= CNT_W'(1);
              busy  <= 1'b1;
            end
          end
        end
        PEND_LO: begin
          if (s2) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            q     <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= INIT_LEVEL ? STABLE_HI : STABLE_LO;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
